// File: rtl/sar_compare_search.sv
// sar_compare_search: successive-approximation initiator for the cascadable
// magnitude comparator. It drives guesses on oGuess/oReq, consumes the
// {gt,lt,eq} code on iAck, and binary-searches the comparator's hidden operand.
//
// state | meaning
// IDLE  | waiting for iStart; result registers hold the last search outcome
// CALC  | register the midpoint of [lo,hi] as the next guess, raise oReq
// REQ   | guess presented; wait for iAck, then narrow the range or finish
// DONE  | single-cycle completion, oDone high, then back to IDLE
module sar_compare_search #(
  parameter int WIDTH = 4
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iStart,
  output logic [WIDTH-1:0] oGuess,
  output logic             oReq,
  input  logic             iAck,
  input  logic [2:0]       iCmp,
  output logic             oBusy,
  output logic             oDone,
  output logic             oFound,
  output logic             oErr,
  output logic [WIDTH-1:0] oResult,
  output logic [3:0]       oSteps
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0]     CMP_GT  = 3'b100;
  localparam logic [2:0]     CMP_LT  = 3'b010;
  localparam logic [2:0]     CMP_EQ  = 3'b001;
  localparam logic [WIDTH:0] HI_INIT = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  state_t state;

  // One extra bit on the bounds so lo can step past the top of the range
  // (guess = all-ones answered "greater") and the empty range is detectable.
  logic [WIDTH:0] lo;
  logic [WIDTH:0] hi;

  logic [WIDTH:0] midSum;
  logic [WIDTH:0] guessExt;
  logic [WIDTH:0] guessInc;
  logic [WIDTH:0] guessDec;
  logic [WIDTH:0] loNext;
  logic [WIDTH:0] hiNext;
  logic           ackContinue;
  logic           ackFound;
  logic           ackErr;
  logic           unusedMidLsb;

  // In CALC lo <= hi <= 2^WIDTH-1, so lo+hi fits in WIDTH+1 bits and the
  // midpoint is simply the upper WIDTH bits of the sum.
  assign midSum       = lo + hi;
  assign unusedMidLsb = midSum[0];
  assign guessExt     = {1'b0, oGuess};
  assign guessInc     = guessExt + ONE_EXT;
  assign guessDec     = guessExt - ONE_EXT;

  // Decode the comparator answer into the narrowed range and the search outcome.
  always_comb begin
    loNext      = lo;
    hiNext      = hi;
    ackContinue = 1'b0;
    ackFound    = 1'b0;
    ackErr      = 1'b0;
    case (iCmp)
      CMP_GT: begin
        loNext = guessInc;
        if (guessInc > hi) begin
          ackErr = 1'b1;
        end else begin
          ackContinue = 1'b1;
        end
      end
      CMP_LT: begin
        // Target below guess 0 cannot exist; guessDec would wrap, so stop here.
        if (oGuess == '0) begin
          ackErr = 1'b1;
        end else begin
          hiNext = guessDec;
          if (lo > guessDec) begin
            ackErr = 1'b1;
          end else begin
            ackContinue = 1'b1;
          end
        end
      end
      CMP_EQ: begin
        ackFound = 1'b1;
      end
      default: begin
        ackErr = 1'b1;
      end
    endcase
  end

  // Search sequencer with all outputs registered.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state   <= IDLE;
      lo      <= '0;
      hi      <= '0;
      oGuess  <= '0;
      oReq    <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oFound  <= 1'b0;
      oErr    <= 1'b0;
      oResult <= '0;
      oSteps  <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            lo      <= '0;
            hi      <= HI_INIT;
            oSteps  <= '0;
            oFound  <= 1'b0;
            oErr    <= 1'b0;
            oResult <= '0;
            oBusy   <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          oGuess <= midSum[WIDTH:1];
          oReq   <= 1'b1;
          state  <= REQ;
        end
        REQ: begin
          if (iAck) begin
            oSteps <= oSteps + 4'd1;
            oReq   <= 1'b0;
            lo     <= loNext;
            hi     <= hiNext;
            if (ackContinue) begin
              state <= CALC;
            end else begin
              // Every terminating answer passes through DONE so oDone is never lost.
              oFound  <= ackFound;
              oErr    <= ackErr;
              oResult <= ackFound ? oGuess : '0;
              oBusy   <= 1'b0;
              oDone   <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_compare_search.sv
// Directed bench for sar_compare_search at WIDTH=4 with a behavioural comparator.
module tb_sar_compare_search;

  localparam int WIDTH = 4;

  logic             iClk;
  logic             iReset;
  logic             iStart;
  logic [WIDTH-1:0] oGuess;
  logic             oReq;
  logic             iAck;
  logic [2:0]       iCmp;
  logic             oBusy;
  logic             oDone;
  logic             oFound;
  logic             oErr;
  logic [WIDTH-1:0] oResult;
  logic [3:0]       oSteps;

  int assertions = 0;
  int failures   = 0;

  int         guessLog[$];
  logic [2:0] forcedCodes[$];
  int         doneCycles;
  bit         timedOut;
  bit         stableOk;

  sar_compare_search #(.WIDTH(WIDTH)) dut (
    .iClk    (iClk),
    .iReset  (iReset),
    .iStart  (iStart),
    .oGuess  (oGuess),
    .oReq    (oReq),
    .iAck    (iAck),
    .iCmp    (iCmp),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oFound  (oFound),
    .oErr    (oErr),
    .oResult (oResult),
    .oSteps  (oSteps)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] pickCode(input int target, input int g);
    if (forcedCodes.size() > 0) return forcedCodes.pop_front();
    if (target > g) return 3'b100;
    if (target < g) return 3'b010;
    return 3'b001;
  endfunction

  function automatic string fmtLog();
    string s = "";
    foreach (guessLog[i]) s = {s, $sformatf("%0d ", guessLog[i])};
    return s;
  endfunction

  // Comparator responder: answers each request after ackDelay waiting cycles
  // (ackDelay 0 ties iAck high), returns at the negedge where oDone is seen.
  task automatic serveUntilDone(input int target, input int ackDelay);
    int waitCnt;
    logic [WIDTH-1:0] held;
    guessLog.delete();
    doneCycles = 0;
    timedOut   = 1'b1;
    stableOk   = 1'b1;
    waitCnt    = 0;
    held       = '0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge iClk);
      if (oDone) begin
        doneCycles = cyc;
        timedOut   = 1'b0;
        break;
      end
      iAck = (ackDelay == 0);
      iCmp = 3'b000;
      if (oReq) begin
        if (waitCnt == 0) held = oGuess;
        else if (oGuess !== held) stableOk = 1'b0;
        if (waitCnt >= ackDelay) begin
          iAck = 1'b1;
          iCmp = pickCode(target, int'(oGuess));
          guessLog.push_back(int'(oGuess));
          waitCnt = 0;
        end else begin
          waitCnt++;
        end
      end else if (waitCnt > 0) begin
        stableOk = 1'b0;
      end
    end
    iAck = 1'b0;
    iCmp = 3'b000;
  endtask

  task automatic doSearch(input int target, input int ackDelay);
    @(negedge iClk);
    iStart = 1'b1;
    @(posedge iClk);
    #1 iStart = 1'b0;
    serveUntilDone(target, ackDelay);
  endtask

  task automatic test_reset();
    iReset = 1'b1; iStart = 1'b0; iAck = 1'b0; iCmp = 3'b000;
    repeat (3) @(negedge iClk);
    assertions++;
    if ({oGuess, oReq, oBusy, oDone, oFound, oErr, oResult, oSteps} !== '0) begin
      failures++;
      $display("FAIL reset_values: got guess=%0d req=%b busy=%b done=%b found=%b err=%b result=%0d steps=%0d, want all zero",
               oGuess, oReq, oBusy, oDone, oFound, oErr, oResult, oSteps);
    end
    iStart = 1'b1;
    @(negedge iClk);
    assertions++;
    if (oBusy !== 1'b0) begin
      failures++;
      $display("FAIL reset_beats_start: got busy=%b, want 0", oBusy);
    end
    iReset = 1'b0; iStart = 1'b0;
    repeat (2) @(negedge iClk);
    assertions++;
    if ({oReq, oBusy, oDone} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset: got req/busy/done=%b, want 000", {oReq, oBusy, oDone});
    end
  endtask

  task automatic test_target11();
    doSearch(11, 0);
    assertions++;
    if (timedOut) begin failures++; $display("FAIL t11_timeout: no oDone within 200 cycles"); end
    assertions++;
    if (fmtLog() != "7 11 ") begin failures++; $display("FAIL t11_guesses: got %s, want 7 11", fmtLog()); end
    assertions++;
    if (doneCycles != 5) begin failures++; $display("FAIL t11_latency: got %0d, want 5", doneCycles); end
    assertions++;
    if ({oFound, oErr, oBusy} !== 3'b100) begin
      failures++; $display("FAIL t11_flags: got found/err/busy=%b, want 100", {oFound, oErr, oBusy});
    end
    assertions++;
    if (oResult !== 4'd11) begin failures++; $display("FAIL t11_result: got %0d, want 11", oResult); end
    assertions++;
    if (oSteps !== 4'd2) begin failures++; $display("FAIL t11_steps: got %0d, want 2", oSteps); end
    @(negedge iClk);
    assertions++;
    if (oDone !== 1'b0 || oResult !== 4'd11 || oFound !== 1'b1) begin
      failures++;
      $display("FAIL t11_hold: got done=%b result=%0d found=%b, want 0 11 1", oDone, oResult, oFound);
    end
  endtask

  task automatic test_boundaries();
    doSearch(0, 0);
    assertions++;
    if (timedOut || fmtLog() != "7 3 1 0 ") begin
      failures++; $display("FAIL t0_guesses: got %s timeout=%b, want 7 3 1 0", fmtLog(), timedOut);
    end
    assertions++;
    if (oFound !== 1'b1 || oResult !== 4'd0 || oSteps !== 4'd4) begin
      failures++; $display("FAIL t0_result: got found=%b result=%0d steps=%0d, want 1 0 4", oFound, oResult, oSteps);
    end
    doSearch(15, 0);
    assertions++;
    if (timedOut || fmtLog() != "7 11 13 14 15 ") begin
      failures++; $display("FAIL t15_guesses: got %s timeout=%b, want 7 11 13 14 15", fmtLog(), timedOut);
    end
    assertions++;
    if (oFound !== 1'b1 || oResult !== 4'd15 || oSteps !== 4'd5) begin
      failures++; $display("FAIL t15_result: got found=%b result=%0d steps=%0d, want 1 15 5", oFound, oResult, oSteps);
    end
    assertions++;
    if (doneCycles != 11) begin failures++; $display("FAIL t15_latency: got %0d, want 11", doneCycles); end
  endtask

  task automatic test_ack_delay();
    doSearch(5, 3);
    assertions++;
    if (timedOut || fmtLog() != "7 3 5 ") begin
      failures++; $display("FAIL delay_guesses: got %s timeout=%b, want 7 3 5", fmtLog(), timedOut);
    end
    assertions++;
    if (!stableOk) begin failures++; $display("FAIL delay_stable: guess/req changed while waiting for ack"); end
    assertions++;
    if (oFound !== 1'b1 || oResult !== 4'd5 || oSteps !== 4'd3) begin
      failures++; $display("FAIL delay_result: got found=%b result=%0d steps=%0d, want 1 5 3", oFound, oResult, oSteps);
    end
  endtask

  task automatic test_illegal_codes();
    forcedCodes = '{3'b000};
    doSearch(9, 0);
    assertions++;
    if (timedOut || {oErr, oFound} !== 2'b10 || oResult !== 4'd0 || oSteps !== 4'd1) begin
      failures++;
      $display("FAIL code000: got err=%b found=%b result=%0d steps=%0d timeout=%b, want 1 0 0 1 0",
               oErr, oFound, oResult, oSteps, timedOut);
    end
    forcedCodes = '{3'b011};
    doSearch(9, 0);
    assertions++;
    if (timedOut || {oErr, oFound} !== 2'b10 || oResult !== 4'd0 || oSteps !== 4'd1) begin
      failures++;
      $display("FAIL code011: got err=%b found=%b result=%0d steps=%0d timeout=%b, want 1 0 0 1 0",
               oErr, oFound, oResult, oSteps, timedOut);
    end
  endtask

  task automatic test_empty_range();
    forcedCodes = '{3'b010, 3'b010, 3'b010, 3'b010};
    doSearch(0, 0);
    assertions++;
    if (timedOut || fmtLog() != "7 3 1 0 " || oErr !== 1'b1 || oFound !== 1'b0 || oSteps !== 4'd4) begin
      failures++;
      $display("FAIL lt_at_zero: got %s err=%b found=%b steps=%0d, want 7 3 1 0 1 0 4", fmtLog(), oErr, oFound, oSteps);
    end
    forcedCodes = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    doSearch(0, 0);
    assertions++;
    if (timedOut || fmtLog() != "7 11 13 14 15 " || oErr !== 1'b1 || oResult !== 4'd0 || oSteps !== 4'd5) begin
      failures++;
      $display("FAIL gt_at_top: got %s err=%b result=%0d steps=%0d, want 7 11 13 14 15 1 0 5", fmtLog(), oErr, oResult, oSteps);
    end
    forcedCodes = '{3'b100, 3'b010, 3'b010, 3'b010};
    doSearch(0, 0);
    assertions++;
    if (timedOut || fmtLog() != "7 11 9 8 " || oErr !== 1'b1 || oFound !== 1'b0 || oSteps !== 4'd4) begin
      failures++;
      $display("FAIL lo_above_hi: got %s err=%b found=%b steps=%0d, want 7 11 9 8 1 0 4", fmtLog(), oErr, oFound, oSteps);
    end
  endtask

  task automatic test_reset_mid_req();
    int reqSeen;
    int doneSeen;
    @(negedge iClk);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    reqSeen = 0;
    for (int i = 0; i < 20 && reqSeen < 2; i++) begin
      @(negedge iClk);
      iAck = 1'b0;
      if (oReq) begin
        reqSeen++;
        if (reqSeen == 1) begin
          iAck = 1'b1;
          iCmp = 3'b010;
        end
      end
    end
    assertions++;
    if (reqSeen != 2 || oGuess !== 4'd3) begin
      failures++; $display("FAIL rst_second_req: got req count %0d guess %0d, want 2 3", reqSeen, oGuess);
    end
    @(negedge iClk);
    iReset = 1'b1;
    @(negedge iClk);
    iReset = 1'b0;
    assertions++;
    if ({oGuess, oReq, oBusy, oDone, oFound, oErr, oResult, oSteps} !== '0) begin
      failures++;
      $display("FAIL rst_mid_req: got guess=%0d req=%b busy=%b done=%b found=%b err=%b result=%0d steps=%0d, want all zero",
               oGuess, oReq, oBusy, oDone, oFound, oErr, oResult, oSteps);
    end
    doneSeen = 0;
    repeat (6) begin
      @(negedge iClk);
      if (oDone || oBusy || oReq) doneSeen++;
    end
    assertions++;
    if (doneSeen != 0) begin failures++; $display("FAIL rst_no_done: got %0d active cycles, want 0", doneSeen); end
    doSearch(9, 0);
    assertions++;
    if (timedOut || fmtLog() != "7 11 9 " || oResult !== 4'd9 || oSteps !== 4'd3 || oFound !== 1'b1) begin
      failures++;
      $display("FAIL rst_rerun: got %s result=%0d steps=%0d found=%b, want 7 11 9 9 3 1", fmtLog(), oResult, oSteps, oFound);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge iClk);
    iStart = 1'b1;
    serveUntilDone(11, 0);
    assertions++;
    if (timedOut || fmtLog() != "7 11 " || oResult !== 4'd11 || oSteps !== 4'd2) begin
      failures++; $display("FAIL held_first: got %s result=%0d steps=%0d, want 7 11 11 2", fmtLog(), oResult, oSteps);
    end
    @(negedge iClk);
    assertions++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) begin
      failures++; $display("FAIL held_idle: got done=%b busy=%b, want 0 0", oDone, oBusy);
    end
    @(negedge iClk);
    assertions++;
    if (oBusy !== 1'b1 || oSteps !== 4'd0 || oFound !== 1'b0) begin
      failures++; $display("FAIL held_restart: got busy=%b steps=%0d found=%b, want 1 0 0", oBusy, oSteps, oFound);
    end
    serveUntilDone(5, 0);
    iStart = 1'b0;
    assertions++;
    if (timedOut || fmtLog() != "7 3 5 " || oResult !== 4'd5 || oSteps !== 4'd3) begin
      failures++; $display("FAIL held_second: got %s result=%0d steps=%0d, want 7 3 5 5 3", fmtLog(), oResult, oSteps);
    end
    repeat (2) @(negedge iClk);
    assertions++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      failures++; $display("FAIL held_release: got busy=%b done=%b, want 0 0", oBusy, oDone);
    end
  endtask

  initial begin
    iReset = 1'b1;
    iStart = 1'b0;
    iAck   = 1'b0;
    iCmp   = 3'b000;
    test_reset();
    test_target11();
    test_boundaries();
    test_ack_delay();
    test_illegal_codes();
    test_empty_range();
    test_reset_mid_req();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
